// File: rtl/ysyx_24100005_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_24100005_mem_pkg
//  Purpose  : Shared types and constants for the load/store memory responder
//  Revision : 1.0  initial release
// ============================================================================
package ysyx_24100005_mem_pkg;

  // Responder control states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Byte address of word 0 of the local storage
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h8000_0000;

  // One write-enable bit per byte lane of a 32-bit word
  localparam int MASK_W = 4;

  // Latency counter width; covers LATENCY values 1..15
  localparam int CNT_W = 4;

endpackage : ysyx_24100005_mem_pkg
`default_nettype wire

// File: rtl/ysyx_24100005_mem_array.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_24100005_mem_array
//  Purpose  : Single-port synchronous word array with byte write enables and
//             a registered read port. Contents are never reset.
//  Revision : 1.0  initial release
// ============================================================================
module ysyx_24100005_mem_array
  import ysyx_24100005_mem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 12,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [MASK_W-1:0]     wmask,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

  // Byte-lane write: only lanes with their mask bit set are updated
  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int b = 0; b < MASK_W; b++) begin
        if (wmask[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Registered read: rdata holds its value until the next read
  always_ff @(posedge clk) begin
    if (en && !we) rdata <= mem[addr];
  end

endmodule : ysyx_24100005_mem_array
`default_nettype wire

// File: rtl/ysyx_24100005_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_24100005_mem_responder
//  Purpose  : Valid/ready load/store responder with programmable latency in
//             front of a local word-addressed storage array.
//  Revision : 1.0  initial release
// ============================================================================
module ysyx_24100005_mem_responder
  import ysyx_24100005_mem_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter int                DEPTH_LOG2 = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = ADDR_W'(DEFAULT_BASE_ADDR),
  parameter int                LATENCY    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [MASK_W-1:0] req_wmask,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  // Size of the mapped window in bytes
  localparam logic [ADDR_W-1:0] SPAN = ADDR_W'(64'd4 << DEPTH_LOG2);

  state_t                 state;
  state_t                 next_state;
  logic [CNT_W-1:0]       cnt;
  logic                   wen_q;
  logic                   in_range_q;
  logic [DEPTH_LOG2-1:0]  index_q;
  logic [DATA_W-1:0]      wdata_q;
  logic [MASK_W-1:0]      wmask_q;
  logic                   err_q;
  logic                   rd_ok_q;
  logic [DATA_W-1:0]      arr_rdata;

  // Unsigned subtraction: addresses below the base wrap high and fail the check
  logic [ADDR_W-1:0] offset;
  logic              in_range;
  logic              accept;
  logic              commit;

  assign offset   = req_addr - BASE_ADDR;
  assign in_range = (offset < SPAN);
  assign accept   = (state == IDLE) && req_valid;
  assign commit   = (state == WAIT) && (cnt == '0);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // Next-state and handshake outputs
  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) next_state = WAIT;
      end
      WAIT: begin
        if (cnt == '0) next_state = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Latency counter: loaded on accept, counts down while waiting
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= CNT_W'(LATENCY - 1);
    end else if ((state == WAIT) && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Request capture; inputs are only sampled on accept
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wen_q      <= 1'b0;
      in_range_q <= 1'b0;
      index_q    <= '0;
      wdata_q    <= '0;
      wmask_q    <= '0;
    end else if (accept) begin
      wen_q      <= req_wen;
      in_range_q <= in_range;
      index_q    <= offset[DEPTH_LOG2+1:2];
      wdata_q    <= req_wdata;
      wmask_q    <= req_wmask;
    end
  end

  // Response status, set at commit and held through the response phase
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q   <= 1'b0;
      rd_ok_q <= 1'b0;
    end else if (commit) begin
      err_q   <= !in_range_q;
      rd_ok_q <= in_range_q && !wen_q;
    end
  end

  // Read data is only exposed for in-range reads; writes and errors return 0
  assign rsp_rdata = rd_ok_q ? arr_rdata : '0;
  assign rsp_err   = err_q;

  ysyx_24100005_mem_array #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .DATA_W     (DATA_W)
  ) u_array (
    .clk   (clk),
    .en    (commit && in_range_q),
    .we    (wen_q),
    .wmask (wmask_q),
    .addr  (index_q),
    .wdata (wdata_q),
    .rdata (arr_rdata)
  );

endmodule : ysyx_24100005_mem_responder
`default_nettype wire
